aes_input_loader: RTL and testbench

- Upstream sequencer for the AES datapath. It feeds key_expansion and cipher.
- Collects a key (128/192/256-bit) and one 128-bit plaintext block from a byte-wide valid/ready stream.
- Presents them on the Key/Data buses, pulses Load to key_expansion, waits for the round-key pipeline to prime, then holds E to cipher until cipher raises EndFlag.
- Lets one host interface drive a full encryption without hand-timed Load/E sequencing.

---
 rtl/aes_input_loader_if.sv | 31 +++
 rtl/aes_input_loader.sv | 159 +++++++++++++++
 tb/tb_aes_input_loader.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_input_loader_if.sv
// Host/datapath bus of the AES input loader: byte stream in, Key/Data/mode and
// Load/E sequencing out, plus the loader's FSM state for observation.
interface aes_input_loader_if;
  // Byte stream handshake: a byte moves on a rising clk edge exactly when
  // in_valid and in_ready are both 1; in_valid with in_ready=0 is dropped.
  logic         start;
  logic [1:0]   mode_in;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] Key;
  logic [127:0] Data;
  logic [1:0]   mode;
  logic         Load;
  logic         E;
  logic         EndFlag;
  logic         busy;
  logic         done;
  logic         err;
  logic [2:0]   dbg_state;

  modport master (
    output start, mode_in, in_byte, in_valid, EndFlag,
    input  in_ready, Key, Data, mode, Load, E, busy, done, err, dbg_state
  );

  modport slave (
    input  start, mode_in, in_byte, in_valid, EndFlag,
    output in_ready, Key, Data, mode, Load, E, busy, done, err, dbg_state
  );
endinterface

// File: rtl/aes_input_loader.sv
// Collects a key and one plaintext block from a byte stream, then sequences
// Load to key_expansion and E to cipher until cipher reports EndFlag.
module aes_input_loader #(
  parameter int KEY_WAIT = 5
) (
  input logic               clk,
  input logic               r,
  aes_input_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_KEY  = 3'd1,
    S_DATA = 3'd2,
    S_LOAD = 3'd3,
    S_WAIT = 3'd4,
    S_RUN  = 3'd5
  } state_t;

  localparam logic [5:0] WAIT_LAST = 6'(KEY_WAIT - 1);
  localparam logic [5:0] DATA_LAST = 6'd15;

  state_t       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [255:0] key_q, key_d;
  logic [127:0] data_q, data_d;
  logic [1:0]   mode_q, mode_d;
  logic         load_q, load_d;
  logic         e_q, e_d;
  logic         in_ready_q, in_ready_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic [5:0]   key_last;
  logic         accept;

  // A byte counts only against the in_ready the host actually saw this cycle.
  assign accept = bus.in_valid & in_ready_q;

  always_comb begin
    case (mode_q)
      2'd1:    key_last = 6'd23;
      2'd2:    key_last = 6'd31;
      default: key_last = 6'd15;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    data_d  = data_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.mode_in == 2'd3) begin
            err_d = 1'b1;
          end else begin
            mode_d  = bus.mode_in;
            key_d   = '0;
            data_d  = '0;
            cnt_d   = '0;
            state_d = S_KEY;
          end
        end
      end
      S_KEY: begin
        if (accept) begin
          key_d = {key_q[247:0], bus.in_byte};
          if (cnt_q == key_last) begin
            cnt_d   = '0;
            state_d = S_DATA;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          data_d = {data_q[119:0], bus.in_byte};
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = S_LOAD;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Hold off E while key_expansion primes its round-key pipeline.
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_RUN: begin
        if (bus.EndFlag) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Strobes follow the state being entered so every output is a flop.
    load_d     = (state_d == S_LOAD);
    e_d        = (state_d == S_RUN);
    in_ready_d = (state_d == S_KEY) || (state_d == S_DATA);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      key_q      <= '0;
      data_q     <= '0;
      mode_q     <= '0;
      load_q     <= 1'b0;
      e_q        <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      data_q     <= data_d;
      mode_q     <= mode_d;
      load_q     <= load_d;
      e_q        <= e_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.Key       = key_q;
  assign bus.Data      = data_q;
  assign bus.mode      = mode_q;
  assign bus.Load      = load_q;
  assign bus.E         = e_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_aes_input_loader.sv
// Directed bench for aes_input_loader: byte loading for all key sizes, Load/E
// timing, protocol abuse, mid-job reset and back-to-back jobs.
module tb_aes_input_loader;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_KEY  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_LOAD = 3'd3;
  localparam logic [2:0] ST_RUN  = 3'd5;

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] D128 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] D2   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;

  logic clk;
  logic r;
  int   tests;
  int   failed;

  aes_input_loader_if bus ();

  aes_input_loader #(.KEY_WAIT(5)) dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [1:0] m);
    bus.start   = 1'b1;
    bus.mode_in = m;
    tick();
    bus.start   = 1'b0;
  endtask

  // Sends the low n bytes of v, most significant byte first, with optional idle gaps.
  task automatic send_vec(input logic [255:0] v, input int n, input int max_gap);
    int gap;
    for (int i = 0; i < n; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      bus.in_valid = 1'b0;
      repeat (gap) tick();
      bus.in_valid = 1'b1;
      bus.in_byte  = v[8*(n-1-i) +: 8];
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_e(output int n);
    n = 0;
    while (bus.E !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic end_job();
    bus.EndFlag = 1'b1;
    tick();
    bus.EndFlag = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    r = 1'b1;
    tick();
    tick();
    tests++;
    if ({bus.Key, bus.Data, bus.mode, bus.Load, bus.E, bus.in_ready, bus.busy, bus.done, bus.err, bus.dbg_state} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: Key=%h Data=%h mode=%0d Load=%b E=%b rdy=%b busy=%b done=%b err=%b st=%0d, required all zero",
               bus.Key, bus.Data, bus.mode, bus.Load, bus.E, bus.in_ready, bus.busy, bus.done, bus.err, bus.dbg_state);
    end
    r = 1'b0;
    tick();
  endtask

  task automatic test_128();
    start_job(2'd0);
    tests++;
    if ({bus.busy, bus.in_ready, bus.dbg_state} !== {2'b11, ST_KEY}) begin
      failed++;
      $display("FAIL 128_start: busy=%b rdy=%b st=%0d, required busy=1 rdy=1 st=%0d", bus.busy, bus.in_ready, bus.dbg_state, ST_KEY);
    end
    send_vec({128'h0, K128}, 16, 0);
    tests++;
    if ({bus.Key, bus.dbg_state} !== {{128'h0, K128}, ST_DATA}) begin
      failed++;
      $display("FAIL 128_key: Key=%h st=%0d, required Key=%h st=%0d", bus.Key, bus.dbg_state, {128'h0, K128}, ST_DATA);
    end
    send_vec({128'h0, D128}, 16, 0);
    tests++;
    if ({bus.Load, bus.in_ready, bus.dbg_state, bus.Data, bus.mode} !== {2'b10, ST_LOAD, D128, 2'd0}) begin
      failed++;
      $display("FAIL 128_load: Load=%b rdy=%b st=%0d Data=%h mode=%0d, required Load=1 rdy=0 st=%0d Data=%h mode=0",
               bus.Load, bus.in_ready, bus.dbg_state, bus.Data, bus.mode, ST_LOAD, D128);
    end
    for (int i = 1; i <= 6; i++) begin
      tick();
      tests++;
      if ({bus.Load, bus.E} !== {1'b0, (i == 6)}) begin
        failed++;
        $display("FAIL 128_e_timing: cycle %0d after Load: Load=%b E=%b, required Load=0 E=%b", i, bus.Load, bus.E, (i == 6));
      end
    end
    repeat (3) tick();
    tests++;
    if ({bus.E, bus.busy, bus.dbg_state} !== {2'b11, ST_RUN}) begin
      failed++;
      $display("FAIL 128_run_hold: E=%b busy=%b st=%0d, required E=1 busy=1 st=%0d", bus.E, bus.busy, bus.dbg_state, ST_RUN);
    end
    end_job();
    tests++;
    if ({bus.E, bus.done, bus.busy, bus.dbg_state} !== {3'b010, ST_IDLE}) begin
      failed++;
      $display("FAIL 128_done: E=%b done=%b busy=%b st=%0d, required E=0 done=1 busy=0 st=0", bus.E, bus.done, bus.busy, bus.dbg_state);
    end
    tick();
    tests++;
    if ({bus.done, bus.Key, bus.Data} !== {1'b0, {128'h0, K128}, D128}) begin
      failed++;
      $display("FAIL 128_after: done=%b Key=%h Data=%h, required done=0 and job values retained", bus.done, bus.Key, bus.Data);
    end
  endtask

  task automatic test_256();
    int n;
    start_job(2'd2);
    send_vec(K256, 32, 0);
    tests++;
    if ({bus.Key, bus.dbg_state} !== {K256, ST_DATA}) begin
      failed++;
      $display("FAIL 256_key: Key=%h st=%0d, required Key=%h st=%0d", bus.Key, bus.dbg_state, K256, ST_DATA);
    end
    send_vec({128'h0, D2} >> 8, 15, 0);
    tests++;
    if ({bus.Load, bus.in_ready} !== 2'b01) begin
      failed++;
      $display("FAIL 256_47_bytes: Load=%b rdy=%b, required Load=0 rdy=1", bus.Load, bus.in_ready);
    end
    send_vec({248'h0, D2[7:0]}, 1, 0);
    tests++;
    if ({bus.Load, bus.Data, bus.Key, bus.mode} !== {1'b1, D2, K256, 2'd2}) begin
      failed++;
      $display("FAIL 256_load: Load=%b Data=%h Key=%h mode=%0d, required Load=1 Data=%h mode=2", bus.Load, bus.Data, bus.Key, bus.mode, D2);
    end
    wait_e(n);
    tests++;
    if (n !== 6) begin
      failed++;
      $display("FAIL 256_e_delay: E rose %0d cycles after Load, required 6", n);
    end
    end_job();
  endtask

  task automatic test_192_stalls();
    int n;
    start_job(2'd1);
    send_vec({64'h0, K192} >> 8, 23, 3);
    tests++;
    if (bus.dbg_state !== ST_KEY) begin
      failed++;
      $display("FAIL 192_23_bytes: st=%0d, required %0d", bus.dbg_state, ST_KEY);
    end
    send_vec({248'h0, K192[7:0]}, 1, 3);
    tests++;
    if ({bus.Key, bus.dbg_state} !== {{64'h0, K192}, ST_DATA}) begin
      failed++;
      $display("FAIL 192_key: Key=%h st=%0d, required Key=%h st=%0d", bus.Key, bus.dbg_state, {64'h0, K192}, ST_DATA);
    end
    send_vec({128'h0, D128}, 16, 3);
    tests++;
    if ({bus.Load, bus.Data, bus.mode} !== {1'b1, D128, 2'd1}) begin
      failed++;
      $display("FAIL 192_data: Load=%b Data=%h mode=%0d, required Load=1 Data=%h mode=1", bus.Load, bus.Data, bus.mode, D128);
    end
    wait_e(n);
    tests++;
    if (n !== 6) begin
      failed++;
      $display("FAIL 192_e_delay: E rose %0d cycles after Load, required 6", n);
    end
    end_job();
    tick();
  endtask

  task automatic test_abuse();
    int n;
    start_job(2'd3);
    tests++;
    if ({bus.err, bus.busy, bus.mode, bus.dbg_state} !== {2'b10, 2'd1, ST_IDLE}) begin
      failed++;
      $display("FAIL bad_mode: err=%b busy=%b mode=%0d st=%0d, required err=1 busy=0 mode=1 st=0", bus.err, bus.busy, bus.mode, bus.dbg_state);
    end
    tick();
    tests++;
    if (bus.err !== 1'b0) begin
      failed++;
      $display("FAIL bad_mode_pulse: err=%b, required 0", bus.err);
    end
    start_job(2'd0);
    send_vec({128'h0, K128}, 16, 0);
    send_vec({128'h0, D128} >> 96, 4, 0);
    start_job(2'd2);
    tests++;
    if ({bus.mode, bus.dbg_state} !== {2'd0, ST_DATA}) begin
      failed++;
      $display("FAIL start_in_data: mode=%0d st=%0d, required mode=0 st=%0d", bus.mode, bus.dbg_state, ST_DATA);
    end
    send_vec({128'h0, D128}, 12, 0);
    tests++;
    if ({bus.Load, bus.Data} !== {1'b1, D128}) begin
      failed++;
      $display("FAIL abuse_data: Load=%b Data=%h, required Load=1 Data=%h", bus.Load, bus.Data, D128);
    end
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'hff;
    bus.EndFlag  = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      tests++;
      if ({bus.in_ready, bus.E, bus.done} !== {1'b0, (i == 6), 1'b0}) begin
        failed++;
        $display("FAIL wait_abuse: cycle %0d after Load: rdy=%b E=%b done=%b, required rdy=0 E=%b done=0", i, bus.in_ready, bus.E, bus.done, (i == 6));
      end
    end
    bus.EndFlag = 1'b0;
    repeat (2) tick();
    tests++;
    if ({bus.Data, bus.in_ready, bus.dbg_state} !== {D128, 1'b0, ST_RUN}) begin
      failed++;
      $display("FAIL run_abuse: Data=%h rdy=%b st=%0d, required Data=%h rdy=0 st=%0d", bus.Data, bus.in_ready, bus.dbg_state, D128, ST_RUN);
    end
    bus.in_valid = 1'b0;
    wait_e(n);
    end_job();
    tick();
  endtask

  task automatic test_reset_mid_job();
    int n;
    start_job(2'd2);
    send_vec(K256 >> 176, 10, 0);
    r = 1'b1;
    tick();
    r = 1'b0;
    tests++;
    if ({bus.Key, bus.mode, bus.busy, bus.in_ready, bus.dbg_state} !== '0) begin
      failed++;
      $display("FAIL reset_in_key: Key=%h mode=%0d busy=%b rdy=%b st=%0d, required all zero", bus.Key, bus.mode, bus.busy, bus.in_ready, bus.dbg_state);
    end
    start_job(2'd1);
    send_vec({64'h0, K192}, 24, 0);
    send_vec({128'h0, D2}, 16, 0);
    wait_e(n);
    r = 1'b1;
    tick();
    r = 1'b0;
    tests++;
    if ({bus.Key, bus.Data, bus.mode, bus.Load, bus.E, bus.in_ready, bus.busy, bus.done, bus.err, bus.dbg_state} !== '0) begin
      failed++;
      $display("FAIL reset_in_run: Key=%h Data=%h mode=%0d E=%b busy=%b st=%0d, required all zero", bus.Key, bus.Data, bus.mode, bus.E, bus.busy, bus.dbg_state);
    end
    start_job(2'd0);
    send_vec({128'h0, K128}, 16, 0);
    send_vec({128'h0, D128}, 16, 0);
    wait_e(n);
    end_job();
    tests++;
    if ({bus.done, bus.Key, bus.Data, bus.mode} !== {1'b1, {128'h0, K128}, D128, 2'd0}) begin
      failed++;
      $display("FAIL reset_fresh_job: done=%b Key=%h Data=%h mode=%0d, required done=1 Key=%h Data=%h mode=0",
               bus.done, bus.Key, bus.Data, bus.mode, {128'h0, K128}, D128);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'haa;
    start_job(2'd1);
    bus.in_valid = 1'b0;
    tests++;
    if ({bus.Key, bus.Data, bus.mode, bus.dbg_state} !== {256'h0, 128'h0, 2'd1, ST_KEY}) begin
      failed++;
      $display("FAIL b2b_clear: Key=%h Data=%h mode=%0d st=%0d, required Key=0 Data=0 mode=1 st=%0d", bus.Key, bus.Data, bus.mode, bus.dbg_state, ST_KEY);
    end
    send_vec({64'h0, K192}, 24, 0);
    tests++;
    if (bus.Key !== {64'h0, K192}) begin
      failed++;
      $display("FAIL b2b_key: Key=%h, required %h", bus.Key, {64'h0, K192});
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    tests        = 0;
    failed       = 0;
    r            = 1'b1;
    bus.start    = 1'b0;
    bus.mode_in  = 2'd0;
    bus.in_byte  = 8'h00;
    bus.in_valid = 1'b0;
    bus.EndFlag  = 1'b0;
    test_reset();
    test_128();
    test_256();
    test_192_stalls();
    test_abuse();
    test_reset_mid_job();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
